// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path.
// Patterns are active-high, bit order {g,f,e,d,c,b,a}; polarity is applied at the
// output registers of the scanner, never here.
package seg7_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;  // shown for non-BCD codes A..F
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg_decode.sv
// BCD to 7-segment decoder, purely combinational.
// Ports:
//   bcd_i      4-bit BCD digit
//   pattern_o  active-high segment pattern {g,f,e,d,c,b,a}; A..F decode to a dash
module bcd_seg_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_i,
  output logic [6:0]         pattern_o
);

  always_comb begin
    // NOTE: the default arm makes the case full (and handles A..F), so no latch is inferred.
    case (bcd_i)
      4'd0:    pattern_o = SEG_0;
      4'd1:    pattern_o = SEG_1;
      4'd2:    pattern_o = SEG_2;
      4'd3:    pattern_o = SEG_3;
      4'd4:    pattern_o = SEG_4;
      4'd5:    pattern_o = SEG_5;
      4'd6:    pattern_o = SEG_6;
      4'd7:    pattern_o = SEG_7;
      4'd8:    pattern_o = SEG_8;
      4'd9:    pattern_o = SEG_9;
      default: pattern_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scan.sv
// Multiplexed 7-segment display scanner for NUM_DIGITS BCD digits.
// Snapshots all digits once per frame, then shows one digit per SCAN_DIV-clock slot.
// Ports:
//   clk, rst     system clock; asynchronous active-high reset (release synchronised upstream)
//   digits_in    BCD digits, digit i = [4i+3:4i], digit NUM_DIGITS-1 most significant
//   dp_in        decimal point per digit, 1 = lit
//   blank_lz     1 = suppress leading zeros (digit 0 always shown)
//   disp_en      0 = all outputs inactive while the scan keeps running in phase
//   seg, dp, an  registered segment, decimal point and one-hot anode outputs
//   frame_start  1-clock pulse when the digit 0 slot begins and the snapshot is taken
module bcd_seg_scan
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic                          blank_lz,
  input  logic                          disp_en,
  output logic [6:0]                    seg,
  output logic                          dp,
  output logic [NUM_DIGITS-1:0]         an,
  output logic                          frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(SCAN_DIV);

  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [6:0]            SEG_IDLE = {7{SEG_ACT_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACT_LOW}};

  logic [PRE_W-1:0]              pre_cnt_q, pre_cnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [DIGIT_W*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [NUM_DIGITS-1:0]         snap_dp_q, snap_dp_d;
  logic                          fs_q, fs_d;
  logic [6:0]                    seg_q, seg_d;
  logic                          dp_q, dp_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;

  logic                          tick;
  logic [DIGIT_W-1:0]            cur_digit;
  logic                          cur_dp;
  logic                          cur_blank;
  logic [NUM_DIGITS-1:0]         an_onehot;
  logic [NUM_DIGITS-1:0]         lead_zero;
  logic [6:0]                    pattern;
  logic [6:0]                    seg_on;

  // Prescaler, digit index and once-per-frame snapshot.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    idx_d     = idx_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    fs_d      = 1'b0;
    if (tick) begin
      if (idx_q == IDX_LAST) begin
        idx_d     = '0;
        snap_d    = digits_in;
        snap_dp_d = dp_in;
        fs_d      = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // Digit select and leading-zero mask, evaluated on the next-state values so the
  // outputs change on the same edge that advances idx.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (snap_d[DIGIT_W*i +: DIGIT_W] == '0);
      lead_zero[i] = zero_run;
    end

    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        cur_digit    = snap_d[DIGIT_W*i +: DIGIT_W];
        cur_dp       = snap_dp_d[i];
        cur_blank    = blank_lz && (i != 0) && lead_zero[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  bcd_seg_decode u_decode (
    .bcd_i     (cur_digit),
    .pattern_o (pattern)
  );

  // A blanked digit keeps its anode and decimal point; only the segments go dark.
  always_comb begin
    seg_on = (disp_en && !cur_blank) ? pattern : SEG_OFF;
    seg_d  = seg_on ^ SEG_IDLE;
    dp_d   = (disp_en && cur_dp) ^ SEG_ACT_LOW;
    an_d   = (disp_en ? an_onehot : '0) ^ AN_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      idx_q     <= IDX_LAST;
      snap_q    <= '0;
      snap_dp_q <= '0;
      fs_q      <= 1'b0;
      seg_q     <= SEG_IDLE;
      dp_q      <= SEG_ACT_LOW;
      an_q      <= AN_IDLE;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      fs_q      <= fs_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan with NUM_DIGITS=4, SCAN_DIV=4, active-low outputs.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic        disp_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_start;

  int n_checks = 0;
  int n_pass   = 0;
  int fs_cnt   = 0;
  int mh_err   = 0;

  // Free-running reference of the scan position.
  logic [1:0] ref_pre;
  logic [1:0] ref_idx;

  always #5 clk = ~clk;

  bcd_seg_scan #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (4),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits_in   (digits_in),
    .dp_in       (dp_in),
    .blank_lz    (blank_lz),
    .disp_en     (disp_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_pre <= 2'd0;
      ref_idx <= 2'd3;
    end else if (ref_pre == 2'd3) begin
      ref_pre <= 2'd0;
      ref_idx <= (ref_idx == 2'd3) ? 2'd0 : ref_idx + 2'd1;
    end else begin
      ref_pre <= ref_pre + 2'd1;
    end
  end

  // frame_start pulses are counted on the edge that ends them.
  always @(posedge clk) if (frame_start === 1'b1) fs_cnt++;

  always @(negedge clk) if (!$onehot0(~an)) mh_err++;

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    digits_in = 16'h0000;
    dp_in     = 4'b0000;
    blank_lz  = 1'b0;
    disp_en   = 1'b1;
    rst       = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(6);
    n_checks++;
    if ({an, seg, dp} !== {4'hE, 7'h40, 1'b1})
      $display("FAIL pre_reset_scan: got an=%h seg=%h dp=%b, expected an=e seg=40 dp=1", an, seg, dp);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL async_reset: got an=%h seg=%h dp=%b fs=%b, expected an=f seg=7f dp=1 fs=0",
               an, seg, dp, frame_start);
    else n_pass++;
    wait_clks(2);
    n_checks++;
    if ({an, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0})
      $display("FAIL reset_hold: got an=%h seg=%h dp=%b fs=%b, expected an=f seg=7f dp=1 fs=0",
               an, seg, dp, frame_start);
    else n_pass++;
  endtask

  task automatic test_scan;
    logic [11:0] exp [4];
    exp = '{{4'hD, 7'h30, 1'b1}, {4'hB, 7'h24, 1'b1}, {4'h7, 7'h79, 1'b1}, {4'hE, 7'h19, 1'b1}};
    digits_in = 16'h1234;
    rst = 1'b0;
    wait_clks(4);
    n_checks++;
    if ({an, seg, dp, frame_start} !== {4'hE, 7'h19, 1'b1, 1'b1})
      $display("FAIL first_slot: got an=%h seg=%h dp=%b fs=%b, expected an=e seg=19 dp=1 fs=1",
               an, seg, dp, frame_start);
    else n_pass++;
    wait_clks(1);
    n_checks++;
    if (frame_start !== 1'b0)
      $display("FAIL fs_width: got fs=%b, expected 0", frame_start);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      wait_clks(k == 0 ? 3 : 4);
      n_checks++;
      if ({an, seg, dp} !== exp[k])
        $display("FAIL scan_slot%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp[k][11:8], exp[k][7:1], exp[k][0]);
      else n_pass++;
    end
  endtask

  task automatic test_snapshot;
    logic [11:0] exp [7];
    exp = '{{4'hD, 7'h30, 1'b1}, {4'hB, 7'h24, 1'b1}, {4'h7, 7'h79, 1'b1},
            {4'hE, 7'h00, 1'b1}, {4'hD, 7'h78, 1'b1}, {4'hB, 7'h02, 1'b1}, {4'h7, 7'h12, 1'b1}};
    wait_clks(4);
    digits_in = 16'h5678;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) wait_clks(4);
      n_checks++;
      if ({an, seg, dp} !== exp[k])
        $display("FAIL snapshot_slot%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp[k][11:8], exp[k][7:1], exp[k][0]);
      else n_pass++;
      if (k == 3) begin
        n_checks++;
        if (frame_start !== 1'b1)
          $display("FAIL snapshot_fs: got fs=%b, expected 1", frame_start);
        else n_pass++;
        fs_cnt = 0;
      end
    end
    wait_clks(4);
    n_checks++;
    if ({an, seg} !== {4'hE, 7'h00})
      $display("FAIL snapshot_wrap: got an=%h seg=%h, expected an=e seg=00", an, seg);
    else n_pass++;
    n_checks++;
    if (fs_cnt !== 1)
      $display("FAIL fs_per_frame: got %0d pulses in 16 clks, expected 1", fs_cnt);
    else n_pass++;
  endtask

  task automatic test_blank;
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    logic [3:0] an_exp [4];
    exp_a  = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    exp_b  = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
    an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
    digits_in = 16'h0050;
    blank_lz  = 1'b1;
    wait_clks(16);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_clks(4);
      n_checks++;
      if ({an, seg, dp} !== {an_exp[k], exp_a[k], 1'b1})
        $display("FAIL blank_0050_d%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
                 k, an, seg, dp, an_exp[k], exp_a[k]);
      else n_pass++;
    end
    digits_in = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      wait_clks(4);
      n_checks++;
      if ({an, seg, dp} !== {an_exp[k], exp_b[k], 1'b1})
        $display("FAIL blank_0000_d%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=1",
                 k, an, seg, dp, an_exp[k], exp_b[k]);
      else n_pass++;
    end
    blank_lz = 1'b0;
    wait_clks(1);
    n_checks++;
    if ({an, seg} !== {4'h7, 7'h40})
      $display("FAIL unblank_next_edge: got an=%h seg=%h, expected an=7 seg=40", an, seg);
    else n_pass++;
    wait_clks(3);
  endtask

  task automatic test_dash_dp;
    logic [11:0] exp [4];
    exp = '{{4'hE, 7'h78, 1'b1}, {4'hD, 7'h30, 1'b1}, {4'hB, 7'h3F, 1'b0}, {4'h7, 7'h3F, 1'b1}};
    digits_in = 16'hFA37;
    dp_in     = 4'b0100;
    wait_clks(16);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) wait_clks(4);
      n_checks++;
      if ({an, seg, dp} !== exp[k])
        $display("FAIL dash_dp_slot%0d: got an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                 k, an, seg, dp, exp[k][11:8], exp[k][7:1], exp[k][0]);
      else n_pass++;
    end
  endtask

  task automatic test_disable;
    int bad;
    bad = 0;
    wait_clks(2);
    disp_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      wait_clks(1);
      if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
        $display("FAIL disabled_cycle%0d: got an=%h seg=%h dp=%b, expected an=f seg=7f dp=1",
                 k, an, seg, dp);
        bad++;
      end
    end
    n_checks++;
    if (bad == 0) n_pass++;
    disp_en = 1'b1;
    wait_clks(1);
    n_checks++;
    if ({an, seg, dp} !== {4'hB, 7'h3F, 1'b0})
      $display("FAIL reenable_phase: got an=%h seg=%h dp=%b, expected an=b seg=3f dp=0", an, seg, dp);
    else n_pass++;
    n_checks++;
    if (an !== ~(4'b0001 << ref_idx))
      $display("FAIL reenable_ref_idx: got an=%h, expected an=%h", an, ~(4'b0001 << ref_idx));
    else n_pass++;
    wait_clks(8);
    n_checks++;
    if (an !== ~(4'b0001 << ref_idx))
      $display("FAIL ref_idx_track: got an=%h, expected an=%h", an, ~(4'b0001 << ref_idx));
    else n_pass++;
    n_checks++;
    if (mh_err !== 0)
      $display("FAIL an_multihot: got %0d multi-hot cycles, expected 0", mh_err);
    else n_pass++;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_snapshot;
    test_blank;
    test_dash_dp;
    test_disable;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
